// File: rtl/goe_if.sv
// goe_if: packet-generator (pgm) to group-output-engine bus.
// Carries packet beats, packet-valid flags and PHVs toward goe, and the two
// almost-full indications back toward pgm.
//   master : pgm side (drives strobes/data, receives almost-full flags)
//   slave  : goe side
interface goe_if;
  logic          in_goe_data_wr;
  logic [133:0]  in_goe_data;
  logic          in_goe_valid_wr;
  logic          in_goe_valid;
  logic          out_goe_alf;
  logic [1023:0] in_goe_phv;
  logic          in_goe_phv_wr;
  logic          out_goe_phv_alf;

  modport master (
    output in_goe_data_wr, in_goe_data, in_goe_valid_wr, in_goe_valid,
           in_goe_phv, in_goe_phv_wr,
    input  out_goe_alf, out_goe_phv_alf
  );

  modport slave (
    input  in_goe_data_wr, in_goe_data, in_goe_valid_wr, in_goe_valid,
           in_goe_phv, in_goe_phv_wr,
    output out_goe_alf, out_goe_phv_alf
  );
endinterface

// File: rtl/goe.sv
// goe: group output engine, the last stage of the user-module pipeline.
// Buffers beats, valid flags and PHVs from pgm, pairs them in arrival order,
// rewrites the output-port field of each packet's first beat from its PHV and
// forwards or discards the packet. The config chain passes through with one
// register stage. Sent/dropped packet counters saturate.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   pgm_if (slave)        beat/valid/PHV inputs, almost-full outputs
//   pktout_*              output beats and packet-valid strobe
//   in_tx_alf             downstream almost full (sampled only before a send)
//   cin_*/cout_*          config chain
//   goe_pkt_cnt/drop_cnt  forwarded / discarded packet counters
//
// state   | meaning
// IDLE    | waiting for a valid flag and a PHV
// POP     | pop flag+PHV once, then wait for in_tx_alf low if forwarding
// SEND    | stream one beat per cycle to pktout until the last beat
// DISCARD | pop beats silently until the last beat

module goe_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [W-1:0]              i_din,
  input  logic                      i_pop,
  output logic [W-1:0]              o_dout,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  // a push into a full FIFO is silently dropped
  assign w_push = i_push && (int'(r_cnt) != DEPTH);
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // first-word fall-through: head is visible without a read cycle
  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

module goe #(
  parameter int DATA_DEPTH  = 256,
  parameter int VALID_DEPTH = 64,
  parameter int PHV_DEPTH   = 16,
  parameter int DATA_ALF_TH = 192,
  parameter int PHV_ALF_TH  = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  goe_if.slave          pgm_if,
  output logic          pktout_data_wr,
  output logic [133:0]  pktout_data,
  output logic          pktout_data_valid_wr,
  output logic          pktout_data_valid,
  input  logic          in_tx_alf,
  input  logic [133:0]  cin_goe_data,
  input  logic          cin_goe_data_wr,
  output logic          cout_goe_ready,
  output logic [133:0]  cout_goe_data,
  output logic          cout_goe_data_wr,
  input  logic          cin_goe_ready,
  output logic [31:0]   goe_pkt_cnt,
  output logic [31:0]   goe_drop_cnt
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int VAW = $clog2(VALID_DEPTH);
  localparam int PAW = $clog2(PHV_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_POP     = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic         r_pop_done;
  logic         r_fwd;
  logic         r_first;
  logic         r_opv;
  logic [7:0]   r_op;
  logic         r_alf;
  logic         r_phv_alf;
  logic [31:0]  r_pkt_cnt;
  logic [31:0]  r_drop_cnt;
  logic [133:0] r_cdata;
  logic         r_cwr;

  logic [133:0] w_dhead;
  logic [DAW:0] w_dcnt;
  logic [0:0]   w_vhead;
  logic [VAW:0] w_vcnt;
  logic [9:0]   w_phv_in;
  logic [9:0]   w_phead;
  logic [PAW:0] w_pcnt;
  logic         w_unused_phv;

  logic w_dempty;
  logic w_dpop;
  logic w_meta_pop;
  logic w_last;
  logic w_head_fwd;
  logic w_fwd;
  logic w_send_beat;
  logic w_drop_done;

  // only drop, outport-valid and outport are ever consulted, so only
  // those ten PHV bits are buffered
  assign w_phv_in     = {pgm_if.in_goe_phv[1023], pgm_if.in_goe_phv[1016],
                         pgm_if.in_goe_phv[1015:1008]};
  assign w_unused_phv = ^{pgm_if.in_goe_phv[1022:1017], pgm_if.in_goe_phv[1007:0]};

  goe_fifo #(.W(134), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(pgm_if.in_goe_data_wr), .i_din(pgm_if.in_goe_data),
    .i_pop(w_dpop), .o_dout(w_dhead), .o_count(w_dcnt)
  );

  goe_fifo #(.W(1), .DEPTH(VALID_DEPTH)) u_valid_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(pgm_if.in_goe_valid_wr), .i_din(pgm_if.in_goe_valid),
    .i_pop(w_meta_pop), .o_dout(w_vhead), .o_count(w_vcnt)
  );

  goe_fifo #(.W(10), .DEPTH(PHV_DEPTH)) u_phv_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(pgm_if.in_goe_phv_wr), .i_din(w_phv_in),
    .i_pop(w_meta_pop), .o_dout(w_phead), .o_count(w_pcnt)
  );

  assign w_dempty   = (w_dcnt == '0);
  assign w_last     = (w_dhead[133:132] == 2'b10);
  assign w_head_fwd = w_vhead[0] & ~w_phead[9];
  // on the first POP cycle the decision comes straight from the FIFO heads;
  // while holding for in_tx_alf the latched copy is used
  assign w_fwd      = r_pop_done ? r_fwd : w_head_fwd;
  assign w_meta_pop = (r_state == S_POP) && !r_pop_done;
  assign w_dpop     = ((r_state == S_SEND) || (r_state == S_DISCARD)) && !w_dempty;
  assign w_send_beat = (r_state == S_SEND) && !w_dempty;
  assign w_drop_done = (r_state == S_DISCARD) && !w_dempty && w_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if ((w_vcnt != '0) && (w_pcnt != '0)) w_next = S_POP;
      S_POP: begin
        if (!w_fwd)          w_next = S_DISCARD;
        else if (!in_tx_alf) w_next = S_SEND;
      end
      S_SEND:    if (w_send_beat && w_last) w_next = S_IDLE;
      S_DISCARD: if (w_drop_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pop_done <= 1'b0;
      r_fwd      <= 1'b0;
      r_first    <= 1'b0;
      r_opv      <= 1'b0;
      r_op       <= '0;
    end else begin
      r_state    <= w_next;
      r_pop_done <= (r_state == S_POP) && (w_next == S_POP);
      if (w_meta_pop) begin
        r_fwd <= w_head_fwd;
        r_opv <= w_phead[8];
        r_op  <= w_phead[7:0];
      end
      if (r_state == S_POP)  r_first <= 1'b1;
      else if (w_send_beat)  r_first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_alf      <= 1'b0;
      r_phv_alf  <= 1'b0;
      r_cdata    <= '0;
      r_cwr      <= 1'b0;
    end else begin
      if (w_send_beat && w_last && (r_pkt_cnt != 32'hFFFF_FFFF))
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_drop_done && (r_drop_cnt != 32'hFFFF_FFFF))
        r_drop_cnt <= r_drop_cnt + 32'd1;
      r_alf     <= (int'(w_dcnt) >= DATA_ALF_TH) || (int'(w_vcnt) >= VALID_DEPTH - 2);
      r_phv_alf <= (int'(w_pcnt) >= PHV_ALF_TH);
      r_cdata   <= cin_goe_data;
      r_cwr     <= cin_goe_data_wr;
    end
  end

  // outputs are gated by the beat strobe so they read 0 whenever idle
  always_comb begin
    pktout_data = '0;
    if (w_send_beat) begin
      pktout_data = w_dhead;
      if (r_first && r_opv) pktout_data[127:120] = r_op;
    end
  end

  assign pktout_data_wr         = w_send_beat;
  assign pktout_data_valid_wr   = w_send_beat && w_last;
  assign pktout_data_valid      = w_send_beat && w_last;
  assign pgm_if.out_goe_alf     = r_alf;
  assign pgm_if.out_goe_phv_alf = r_phv_alf;
  assign cout_goe_ready         = cin_goe_ready;
  assign cout_goe_data          = r_cdata;
  assign cout_goe_data_wr       = r_cwr;
  assign goe_pkt_cnt            = r_pkt_cnt;
  assign goe_drop_cnt           = r_drop_cnt;
endmodule

// File: tb/tb_goe.sv
module tb_goe;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pktout_data_wr;
  logic [133:0]  pktout_data;
  logic          pktout_data_valid_wr;
  logic          pktout_data_valid;
  logic          in_tx_alf = 1'b0;
  logic [133:0]  cin_goe_data = '0;
  logic          cin_goe_data_wr = 1'b0;
  logic          cout_goe_ready;
  logic [133:0]  cout_goe_data;
  logic          cout_goe_data_wr;
  logic          cin_goe_ready = 1'b0;
  logic [31:0]   goe_pkt_cnt;
  logic [31:0]   goe_drop_cnt;

  goe_if pgm_if ();

  goe dut (
    .clk(clk), .rst_n(rst_n), .pgm_if(pgm_if),
    .pktout_data_wr(pktout_data_wr), .pktout_data(pktout_data),
    .pktout_data_valid_wr(pktout_data_valid_wr), .pktout_data_valid(pktout_data_valid),
    .in_tx_alf(in_tx_alf),
    .cin_goe_data(cin_goe_data), .cin_goe_data_wr(cin_goe_data_wr),
    .cout_goe_ready(cout_goe_ready), .cout_goe_data(cout_goe_data),
    .cout_goe_data_wr(cout_goe_data_wr), .cin_goe_ready(cin_goe_ready),
    .goe_pkt_cnt(goe_pkt_cnt), .goe_drop_cnt(goe_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         nb;
    bit         vld;
    bit         drop;
    bit         opv;
    logic [7:0] op;
    int         exp_pkt;
    int         exp_drop;
  } vec_t;

  typedef struct {
    logic [133:0] d;
    bit           last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   beats_seen = 0;
  int   exp_pkt = 0;
  int   exp_drop = 0;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // reference: every forwarded packet contributes its beats, in order, with
  // the first beat's [127:120] replaced by the outport when outport-valid
  always @(negedge clk) begin
    if (rst_n && pktout_data_wr) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat actual=%h required=none", pktout_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", pktout_data, mon_e.d);
        chk("beat_valid_wr", {133'd0, pktout_data_valid_wr}, {133'd0, mon_e.last});
        chk("beat_valid", {133'd0, pktout_data_valid}, {133'd0, mon_e.last});
      end
    end
  end

  function automatic logic [133:0] mk_beat(input int i, input int nb);
    logic [133:0] b;
    b[127:0]   = {$urandom, $urandom, $urandom, $urandom};
    b[131:128] = 4'($urandom_range(0, 15));
    b[133:132] = (i == 0) ? 2'b01 : ((i == nb - 1) ? 2'b10 : 2'b11);
    return b;
  endfunction

  task automatic push_pkt(input int nb, input bit vld, input bit drop,
                          input bit opv, input logic [7:0] op, input int vgap);
    logic [1023:0] phv;
    logic [133:0]  b;
    exp_t          e;
    bit            fwd;
    fwd = vld && !drop;
    for (int k = 0; k < 32; k++) phv[k*32 +: 32] = $urandom;
    phv[1023]      = drop;
    phv[1016]      = opv;
    phv[1015:1008] = op;
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      b = mk_beat(i, nb);
      pgm_if.in_goe_data_wr  = 1'b1;
      pgm_if.in_goe_data     = b;
      pgm_if.in_goe_phv_wr   = (i == 0);
      pgm_if.in_goe_phv      = phv;
      pgm_if.in_goe_valid_wr = (i == nb - 1) && (vgap == 0);
      pgm_if.in_goe_valid    = vld;
      if (fwd) begin
        e.d = b;
        if (i == 0 && opv) e.d[127:120] = op;
        e.last = (i == nb - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    pgm_if.in_goe_data_wr  = 1'b0;
    pgm_if.in_goe_phv_wr   = 1'b0;
    pgm_if.in_goe_valid_wr = 1'b0;
    if (vgap > 0) begin
      repeat (vgap - 1) @(posedge clk);
      #1;
      pgm_if.in_goe_valid_wr = 1'b1;
      @(posedge clk); #1;
      pgm_if.in_goe_valid_wr = 1'b0;
    end
    if (fwd) exp_pkt++;
    else     exp_drop++;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (30) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pkt_cnt"},  {102'd0, goe_pkt_cnt},  134'(exp_pkt));
    chk({tag, "_drop_cnt"}, {102'd0, goe_drop_cnt}, 134'(exp_drop));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[6];

  initial begin
    logic [133:0] prev_d;
    logic         prev_wr;
    int           s0;
    int           t;

    tbl[0] = '{4, 1'b1, 1'b0, 1'b1, 8'h03, 1, 0};
    tbl[1] = '{4, 1'b1, 1'b1, 1'b1, 8'h03, 1, 1};
    tbl[2] = '{4, 1'b1, 1'b0, 1'b0, 8'h55, 2, 1};
    tbl[3] = '{3, 1'b0, 1'b0, 1'b1, 8'hAA, 2, 2};
    tbl[4] = '{6, 1'b1, 1'b0, 1'b1, 8'hF0, 3, 2};
    tbl[5] = '{2, 1'b1, 1'b0, 1'b1, 8'h11, 4, 2};

    pgm_if.in_goe_data_wr  = 1'b0;
    pgm_if.in_goe_data     = '0;
    pgm_if.in_goe_valid_wr = 1'b0;
    pgm_if.in_goe_valid    = 1'b0;
    pgm_if.in_goe_phv_wr   = 1'b0;
    pgm_if.in_goe_phv      = '0;

    // reset state
    #2 rst_n = 1'b0;
    cin_goe_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_wr",   {133'd0, pktout_data_wr}, 134'd0);
    chk("rst_data",      pktout_data, 134'd0);
    chk("rst_valid_wr",  {133'd0, pktout_data_valid_wr}, 134'd0);
    chk("rst_alf",       {132'd0, pgm_if.out_goe_alf, pgm_if.out_goe_phv_alf}, 134'd0);
    chk("rst_cout",      {cout_goe_data[132:0], cout_goe_data_wr}, 134'd0);
    chk("rst_cnts",      {70'd0, goe_pkt_cnt, goe_drop_cnt}, 134'd0);
    chk("rst_ready",     {133'd0, cout_goe_ready}, 134'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // directed packet table
    foreach (tbl[i]) begin
      push_pkt(tbl[i].nb, tbl[i].vld, tbl[i].drop, tbl[i].opv, tbl[i].op, 0);
      wait_drain();
      chk("tbl_pkt_cnt",  {102'd0, goe_pkt_cnt},  134'(tbl[i].exp_pkt));
      chk("tbl_drop_cnt", {102'd0, goe_drop_cnt}, 134'(tbl[i].exp_drop));
    end

    // in_tx_alf hold with two packets queued
    in_tx_alf = 1'b1;
    push_pkt(4, 1'b1, 1'b0, 1'b1, 8'h21, 0);
    push_pkt(4, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    s0 = beats_seen;
    repeat (20) @(posedge clk);
    #1;
    chk("txalf_hold_beats", 134'(beats_seen), 134'(s0));
    in_tx_alf = 1'b0;
    @(posedge clk); #1;
    chk("txalf_release_first_beat", {133'd0, pktout_data_wr}, 134'd1);
    wait_drain();
    chk_counts("txalf");

    // randomized traffic against the queue model
    for (int n = 0; n < 30; n++) begin
      t = 0;
      while ((pgm_if.out_goe_alf || pgm_if.out_goe_phv_alf) && t < 500) begin
        in_tx_alf = 1'b0;
        @(posedge clk); #1;
        t++;
      end
      in_tx_alf = ($urandom_range(0, 3) == 0);
      push_pkt($urandom_range(2, 6), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
               8'($urandom), $urandom_range(0, 2));
    end
    in_tx_alf = 1'b0;
    wait_drain();
    chk_counts("rand");

    // config chain
    prev_d  = '0;
    prev_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk("cfg_data", cout_goe_data, prev_d);
        chk("cfg_wr", {133'd0, cout_goe_data_wr}, {133'd0, prev_wr});
      end
      cin_goe_data    = {$urandom, $urandom, $urandom, $urandom, 6'($urandom)};
      cin_goe_data_wr = (i % 3 != 2);
      cin_goe_ready   = i[0];
      #1;
      chk("cfg_ready", {133'd0, cout_goe_ready}, {133'd0, i[0]});
      prev_d  = cin_goe_data;
      prev_wr = cin_goe_data_wr;
    end
    @(posedge clk); #1;
    cin_goe_data_wr = 1'b0;

    // almost-full thresholds: 192 beats, then 14 PHVs, nothing drains
    for (int i = 0; i < 192; i++) begin
      @(posedge clk); #1;
      pgm_if.in_goe_data_wr = 1'b1;
      pgm_if.in_goe_data    = mk_beat(1, 4);
    end
    @(posedge clk); #1;
    pgm_if.in_goe_data_wr = 1'b0;
    chk("alf_not_yet", {133'd0, pgm_if.out_goe_alf}, 134'd0);
    @(posedge clk); #1;
    chk("alf_192", {133'd0, pgm_if.out_goe_alf}, 134'd1);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      pgm_if.in_goe_phv_wr = 1'b1;
    end
    @(posedge clk); #1;
    pgm_if.in_goe_phv_wr = 1'b0;
    chk("phv_alf_not_yet", {133'd0, pgm_if.out_goe_phv_alf}, 134'd0);
    @(posedge clk); #1;
    chk("phv_alf_14", {133'd0, pgm_if.out_goe_phv_alf}, 134'd1);
    do_reset();
    @(posedge clk); #1;
    chk("flush_alf", {132'd0, pgm_if.out_goe_alf, pgm_if.out_goe_phv_alf}, 134'd0);

    // reset in the middle of a SEND
    push_pkt(6, 1'b1, 1'b0, 1'b1, 8'h77, 0);
    s0 = beats_seen;
    t = 0;
    while (beats_seen < s0 + 2 && t < 200) begin
      @(posedge clk);
      t++;
    end
    n_vec++;
    if (beats_seen < s0 + 2) begin
      n_err++;
      $display("FAIL midrst_wait beats=%0d required=%0d", beats_seen - s0, 2);
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    #1;
    chk("midrst_data_wr", {133'd0, pktout_data_wr}, 134'd0);
    chk("midrst_data", pktout_data, 134'd0);
    chk("midrst_valid_wr", {133'd0, pktout_data_valid_wr}, 134'd0);
    chk("midrst_cnts", {70'd0, goe_pkt_cnt, goe_drop_cnt}, 134'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = beats_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_partial", 134'(beats_seen), 134'(s0));
    chk_counts("midrst_after");
    push_pkt(5, 1'b1, 1'b0, 1'b1, 8'h3C, 0);
    wait_drain();
    chk_counts("midrst_new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/goe.md
Name: goe

Overview:
- Group output engine. Last stage of the user-module pipeline, directly downstream of the packet generator (pgm).
- Buffers packet beats, packet-valid flags and PHVs from pgm, and pairs them one-to-one in arrival order.
- Rewrites the output-port field of each packet's first beat from its PHV, then forwards or discards the packet toward the transmit interface.
- Passes the configuration-packet chain through with one register stage and keeps sent/dropped packet counters.

Parameters:
- DATA_DEPTH, 256, data FIFO depth in 134-bit beats (power of 2).
- VALID_DEPTH, 64, valid-flag FIFO depth (power of 2).
- PHV_DEPTH, 16, PHV FIFO depth (power of 2).
- DATA_ALF_TH, 192, data FIFO occupancy at or above which out_goe_alf is asserted.
- PHV_ALF_TH, 14, PHV FIFO occupancy at or above which out_goe_phv_alf is asserted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_goe_data_wr  in  1  beat strobe from pgm
- in_goe_data  in  134  beat; [133:132] 01=first, 11=middle, 10=last; [131:128] invalid-byte count; [127:0] payload
- in_goe_valid_wr  in  1  packet-valid strobe, given with or after the last beat
- in_goe_valid  in  1  1=forward, 0=discard
- out_goe_alf  out  1  data/valid almost-full toward pgm
- in_goe_phv  in  1024  PHV from pgm
- in_goe_phv_wr  in  1  PHV strobe
- out_goe_phv_alf  out  1  PHV FIFO almost full
- pktout_data_wr  out  1  output beat strobe
- pktout_data  out  134  output beat
- pktout_data_valid_wr  out  1  output valid strobe
- pktout_data_valid  out  1  always 1 when pktout_data_valid_wr=1
- in_tx_alf  in  1  downstream almost full
- cin_goe_data  in  134  config beat in
- cin_goe_data_wr  in  1  config strobe in
- cout_goe_ready  out  1  config ready to upstream
- cout_goe_data  out  134  config beat out
- cout_goe_data_wr  out  1  config strobe out
- cin_goe_ready  in  1  config ready from downstream
- goe_pkt_cnt  out  32  packets forwarded
- goe_drop_cnt  out  32  packets discarded

Behaviour:
- Reset values: every output is 0, except cout_goe_ready, which tracks cin_goe_ready combinationally. All FIFOs empty; counters 0; FSM in IDLE.
- Reset mid-packet flushes all FIFOs. No partial packet is emitted after reset.
- Write side:
  - in_goe_data_wr pushes to the data FIFO.
  - in_goe_valid_wr pushes in_goe_valid to the valid FIFO.
  - in_goe_phv_wr pushes to the PHV FIFO.
  - All pushes are unconditional; a push into a full FIFO is dropped. The alf thresholds make this an upstream protocol violation.
- out_goe_alf = (data occupancy >= DATA_ALF_TH) OR (valid occupancy >= VALID_DEPTH-2). Registered; updates 1 cycle after the occupancy change.
- out_goe_phv_alf = PHV occupancy >= PHV_ALF_TH. Registered.
- PHV fields:
  - drop = phv[1023].
  - outport-valid = phv[1016].
  - outport = phv[1015:1008].
- FSM states: IDLE, POP, SEND, DISCARD.
  - IDLE -> POP when the valid FIFO and PHV FIFO are both non-empty.
  - POP: pop one valid flag and one PHV; latch drop/outport.
  - POP -> SEND if valid=1 and drop=0 and in_tx_alf=0.
  - POP -> DISCARD if valid=0 or drop=1.
  - POP holds (no pop repeated) while a forward is pending and in_tx_alf=1.
  - SEND: read one beat per cycle from the FWFT data FIFO and drive pktout_data_wr=1.
    - On the first beat, when outport-valid=1, pktout_data[127:120] is replaced by outport.
    - On the last beat ([133:132]=10), also assert pktout_data_valid_wr=1 and pktout_data_valid=1, increment goe_pkt_cnt, and go to IDLE.
  - SEND never stalls: in_tx_alf is sampled only in POP, and downstream guarantees room for a max-size packet after deassert.
  - SEND with the data FIFO empty (beats still arriving): insert idle cycles with pktout_data_wr=0 and continue when data arrives.
  - DISCARD: pop beats through the last beat with no output strobes, increment goe_drop_cnt, then go to IDLE.
- Latency: when both FIFOs are non-empty, the first output beat appears 2 cycles after IDLE observes them. Minimum gap between packets is 2 cycles.
- Packet-level ordering is strictly FIFO. PHV n always pairs with packet n.
- Counters saturate at 32'hFFFF_FFFF.
- Config chain:
  - cout_goe_ready = cin_goe_ready.
  - cout_goe_data and cout_goe_data_wr are cin_goe_data and cin_goe_data_wr delayed 1 cycle.
  - Config traffic is independent of the packet path.

Test Plan:
- 4-beat packet (01,11,11,10), valid=1, PHV with [1016]=1 and [1015:1008]=8'h03 -> 4 output beats; beat 0 has [127:120]=8'h03; valid_wr on beat 3; goe_pkt_cnt=1.
- Same packet with phv[1023]=1 -> zero output strobes; goe_drop_cnt=1. A second valid packet following it is forwarded intact.
- in_tx_alf=1 held for 20 cycles with 2 packets queued -> no output until release; first beat appears 1 cycle after in_tx_alf drops.
- Push 192 beats with no PHVs -> out_goe_alf=1 one cycle after the 192nd push. Push 14 PHVs -> out_goe_phv_alf=1.
- rst_n low during beat 2 of SEND -> all outputs 0 immediately; after release, a new packet is forwarded correctly and counters read 0.
- Config beats on consecutive cycles with cin_goe_ready toggling -> cout_goe_data equals input delayed 1 cycle; cout_goe_ready mirrors cin_goe_ready in the same cycle.
